// File: rtl/execute_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : execute_muldiv
// Description : Handshaked execute stage. It selects the operands, runs the
//               XLEN-wide base ALU, resolves branches and jumps, and executes
//               RV32M/RV64M multiply/divide one radix-2 step per cycle.
//               It holds one op at a time. Results are registered and offered
//               through a valid/ready handshake. flush kills the op in flight.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   XLEN        datapath width (32 or 64)
//   MULDIV_EN   1: M-extension ops executed, 0: M-ops retire in 1 cycle as 0
// Ports
//   clk          in   1     clock
//   rst          in   1     synchronous reset, active low
//   flush        in   1     kill op in flight, ignore same-cycle in_valid
//   in_valid     in   1     decode presents an op
//   in_ready     out  1     stage can accept an op this cycle
//   pc           in   XLEN  PC of incoming op
//   alucode      in   6     ALU operation code
//   aluop1_type  in   2     op1 source (none/reg/imm/pc)
//   aluop2_type  in   2     op2 source (none/reg/imm/pc)
//   rs1, rs2     in   XLEN  register operands
//   imm          in   XLEN  sign-extended immediate
//   out_valid    out  1     result registers hold a completed op
//   out_ready    in   1     downstream consumes the result
//   alu_result   out  XLEN  ALU / mul / div result
//   pc_next      out  XLEN  next PC of completed op
//   br_taken     out  1     branch/jump taken for completed op
//   busy         out  1     multi-cycle op in progress
// ============================================================================
module execute_muldiv #(
    parameter int XLEN      = 32,
    parameter int MULDIV_EN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] pc,
    input  logic [5:0]      alucode,
    input  logic [1:0]      aluop1_type,
    input  logic [1:0]      aluop2_type,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] pc_next,
    output logic            br_taken,
    output logic            busy
);

    // Operand source codes
    localparam logic [1:0] c_op_reg = 2'd1;
    localparam logic [1:0] c_op_imm = 2'd2;
    localparam logic [1:0] c_op_pc  = 2'd3;

    // ALU operation codes
    localparam logic [5:0] c_alu_lui    = 6'd0;
    localparam logic [5:0] c_alu_jal    = 6'd1;
    localparam logic [5:0] c_alu_jalr   = 6'd2;
    localparam logic [5:0] c_alu_beq    = 6'd3;
    localparam logic [5:0] c_alu_bne    = 6'd4;
    localparam logic [5:0] c_alu_blt    = 6'd5;
    localparam logic [5:0] c_alu_bge    = 6'd6;
    localparam logic [5:0] c_alu_bltu   = 6'd7;
    localparam logic [5:0] c_alu_bgeu   = 6'd8;
    localparam logic [5:0] c_alu_lb     = 6'd9;
    localparam logic [5:0] c_alu_lh     = 6'd10;
    localparam logic [5:0] c_alu_lw     = 6'd11;
    localparam logic [5:0] c_alu_lbu    = 6'd12;
    localparam logic [5:0] c_alu_lhu    = 6'd13;
    localparam logic [5:0] c_alu_sb     = 6'd14;
    localparam logic [5:0] c_alu_sh     = 6'd15;
    localparam logic [5:0] c_alu_sw     = 6'd16;
    localparam logic [5:0] c_alu_add    = 6'd17;
    localparam logic [5:0] c_alu_sub    = 6'd18;
    localparam logic [5:0] c_alu_slt    = 6'd19;
    localparam logic [5:0] c_alu_sltu   = 6'd20;
    localparam logic [5:0] c_alu_xor    = 6'd21;
    localparam logic [5:0] c_alu_or     = 6'd22;
    localparam logic [5:0] c_alu_and    = 6'd23;
    localparam logic [5:0] c_alu_sll    = 6'd24;
    localparam logic [5:0] c_alu_srl    = 6'd25;
    localparam logic [5:0] c_alu_sra    = 6'd26;
    localparam logic [5:0] c_alu_mul    = 6'd27;
    localparam logic [5:0] c_alu_mulh   = 6'd28;
    localparam logic [5:0] c_alu_mulhsu = 6'd29;
    localparam logic [5:0] c_alu_mulhu  = 6'd30;
    localparam logic [5:0] c_alu_div    = 6'd31;
    localparam logic [5:0] c_alu_divu   = 6'd32;
    localparam logic [5:0] c_alu_rem    = 6'd33;
    localparam logic [5:0] c_alu_remu   = 6'd34;

    // FSM encoding
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_busy = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam int c_shw  = $clog2(XLEN);
    localparam int c_cntw = $clog2(XLEN + 1);
    localparam logic [c_cntw-1:0] c_cnt_load = c_cntw'(XLEN);
    localparam logic [c_cntw-1:0] c_cnt_one  = c_cntw'(1);
    localparam logic [XLEN-1:0]   c_four     = {{(XLEN-3){1'b0}}, 3'b100};
    localparam logic [XLEN-1:0]   c_one      = {{(XLEN-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [c_cntw-1:0] r_cnt;
    logic [XLEN-1:0]   r_alu_result;
    logic [XLEN-1:0]   r_pc_next;
    logic              r_br_taken;

    // Shared mul/div working registers: hi = partial product / remainder,
    // lo = multiplier / dividend-quotient, b = multiplicand / divisor.
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_b;
    logic              r_neg;
    logic              r_is_div;
    logic              r_sel_hi;

    logic              w_md_en;
    logic              w_accept;
    logic [XLEN-1:0]   w_op1;
    logic [XLEN-1:0]   w_op2;
    logic [c_shw-1:0]  w_sh;
    logic [XLEN-1:0]   w_sum;
    logic [XLEN-1:0]   w_pc_plus4;
    logic [XLEN-1:0]   w_jalr_sum;
    logic              w_lt_s;
    logic              w_lt_u;
    logic [XLEN-1:0]   w_alu_res;
    logic              w_taken;
    logic [XLEN-1:0]   w_pc_nxt_calc;

    logic              w_is_mop;
    logic              w_md_start;
    logic              w_md_div;
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_sel_hi;
    logic              w_a_neg;
    logic              w_b_neg;
    logic              w_b_zero;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_neg_start;

    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_div_sh;
    logic [XLEN:0]     w_div_trial;
    logic              w_div_ge;
    logic [XLEN-1:0]   w_step_hi;
    logic [XLEN-1:0]   w_step_lo;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_div_sel;
    logic [XLEN-1:0]   w_div_fix;
    logic [XLEN-1:0]   w_md_result;

    generate
        if (MULDIV_EN != 0) begin : g_muldiv_on
            assign w_md_en = 1'b1;
        end else begin : g_muldiv_off
            assign w_md_en = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Operand select: unknown source codes give 0, never a stale value
    // ------------------------------------------------------------------
    always_comb begin
        w_op1 = '0;
        case (aluop1_type)
            c_op_reg: w_op1 = rs1;
            c_op_imm: w_op1 = imm;
            c_op_pc:  w_op1 = pc;
            default:  w_op1 = '0;
        endcase
    end

    always_comb begin
        w_op2 = '0;
        case (aluop2_type)
            c_op_reg: w_op2 = rs2;
            c_op_imm: w_op2 = imm;
            c_op_pc:  w_op2 = pc;
            default:  w_op2 = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Base ALU and branch resolution
    // ------------------------------------------------------------------
    assign w_sh       = w_op2[c_shw-1:0];
    assign w_sum      = w_op1 + w_op2;
    assign w_pc_plus4 = pc + c_four;
    assign w_jalr_sum = rs1 + imm;
    assign w_lt_s     = $signed(w_op1) < $signed(w_op2);
    assign w_lt_u     = w_op1 < w_op2;

    always_comb begin
        w_alu_res = '0;
        w_taken   = 1'b0;
        case (alucode)
            c_alu_lui:  w_alu_res = w_op2;
            c_alu_jal,
            c_alu_jalr: begin
                w_alu_res = w_pc_plus4;
                w_taken   = 1'b1;
            end
            c_alu_beq:  w_taken = (w_op1 == w_op2);
            c_alu_bne:  w_taken = (w_op1 != w_op2);
            c_alu_blt:  w_taken = w_lt_s;
            c_alu_bge:  w_taken = ~w_lt_s;
            c_alu_bltu: w_taken = w_lt_u;
            c_alu_bgeu: w_taken = ~w_lt_u;
            c_alu_lb, c_alu_lh, c_alu_lw, c_alu_lbu, c_alu_lhu,
            c_alu_sb, c_alu_sh, c_alu_sw,
            c_alu_add:  w_alu_res = w_sum;
            c_alu_sub:  w_alu_res = w_op1 - w_op2;
            c_alu_slt:  w_alu_res = {{(XLEN-1){1'b0}}, w_lt_s};
            c_alu_sltu: w_alu_res = {{(XLEN-1){1'b0}}, w_lt_u};
            c_alu_xor:  w_alu_res = w_op1 ^ w_op2;
            c_alu_or:   w_alu_res = w_op1 | w_op2;
            c_alu_and:  w_alu_res = w_op1 & w_op2;
            c_alu_sll:  w_alu_res = w_op1 << w_sh;
            c_alu_srl:  w_alu_res = w_op1 >> w_sh;
            c_alu_sra:  w_alu_res = $unsigned($signed(w_op1) >>> w_sh);
            default: ;
        endcase
    end

    always_comb begin
        w_pc_nxt_calc = w_pc_plus4;
        if (w_taken) begin
            if (alucode == c_alu_jalr) begin
                w_pc_nxt_calc = w_jalr_sum & ~c_one;
            end else begin
                w_pc_nxt_calc = pc + imm;
            end
        end
    end

    // ------------------------------------------------------------------
    // M-op decode and magnitude preparation
    // ------------------------------------------------------------------
    assign w_is_mop   = (alucode >= c_alu_mul) && (alucode <= c_alu_remu);
    assign w_md_start = w_is_mop & w_md_en;
    assign w_md_div   = (alucode >= c_alu_div);
    assign w_a_signed = (alucode == c_alu_mul) || (alucode == c_alu_mulh) ||
                        (alucode == c_alu_mulhsu) || (alucode == c_alu_div) ||
                        (alucode == c_alu_rem);
    assign w_b_signed = (alucode == c_alu_mul) || (alucode == c_alu_mulh) ||
                        (alucode == c_alu_div) || (alucode == c_alu_rem);
    assign w_sel_hi   = (alucode == c_alu_mulh) || (alucode == c_alu_mulhsu) ||
                        (alucode == c_alu_mulhu) || (alucode == c_alu_rem) ||
                        (alucode == c_alu_remu);

    assign w_a_neg  = w_a_signed & w_op1[XLEN-1];
    assign w_b_neg  = w_b_signed & w_op2[XLEN-1];
    assign w_a_mag  = w_a_neg ? -w_op1 : w_op1;
    assign w_b_mag  = w_b_neg ? -w_op2 : w_op2;
    assign w_b_zero = (w_op2 == '0);

    // The magnitude divider naturally yields all ones / dividend on a zero
    // divisor; the quotient sign flip is suppressed so DIV x/0 stays all ones.
    always_comb begin
        w_neg_start = w_a_neg ^ w_b_neg;
        if (w_md_div) begin
            if (w_sel_hi) begin
                w_neg_start = w_a_neg;
            end else begin
                w_neg_start = (w_a_neg ^ w_b_neg) & ~w_b_zero;
            end
        end
    end

    // ------------------------------------------------------------------
    // One radix-2 step: shift-add multiply or restoring divide
    // ------------------------------------------------------------------
    assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
    assign w_div_sh    = {r_hi, r_lo[XLEN-1]};
    assign w_div_trial = w_div_sh - {1'b0, r_b};
    assign w_div_ge    = ~w_div_trial[XLEN];

    always_comb begin
        w_step_hi = w_mul_sum[XLEN:1];
        w_step_lo = {w_mul_sum[0], r_lo[XLEN-1:1]};
        if (r_is_div) begin
            w_step_hi = w_div_ge ? w_div_trial[XLEN-1:0] : w_div_sh[XLEN-1:0];
            w_step_lo = {r_lo[XLEN-2:0], w_div_ge};
        end
    end

    // Sign fix-up applied on the final step
    assign w_prod      = {w_step_hi, w_step_lo};
    assign w_prod_fix  = r_neg ? -w_prod : w_prod;
    assign w_div_sel   = r_sel_hi ? w_step_hi : w_step_lo;
    assign w_div_fix   = r_neg ? -w_div_sel : w_div_sel;
    assign w_md_result = r_is_div ? w_div_fix :
                         (r_sel_hi ? w_prod_fix[2*XLEN-1:XLEN] : w_prod_fix[XLEN-1:0]);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = (r_state == c_st_idle) || ((r_state == c_st_done) && out_ready);
        w_accept    = in_valid & in_ready & ~flush;
        if (flush) begin
            w_state_nxt = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        w_state_nxt = w_md_start ? c_st_busy : c_st_done;
                    end
                end
                c_st_busy: begin
                    if (r_cnt == c_cnt_one) begin
                        w_state_nxt = c_st_done;
                    end
                end
                c_st_done: begin
                    if (w_accept) begin
                        w_state_nxt = w_md_start ? c_st_busy : c_st_done;
                    end else if (out_ready) begin
                        w_state_nxt = c_st_idle;
                    end
                end
                default: w_state_nxt = c_st_idle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= c_st_idle;
            r_cnt        <= '0;
            r_alu_result <= '0;
            r_pc_next    <= '0;
            r_br_taken   <= 1'b0;
            r_hi         <= '0;
            r_lo         <= '0;
            r_b          <= '0;
            r_neg        <= 1'b0;
            r_is_div     <= 1'b0;
            r_sel_hi     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (flush) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                // M-ops never take a branch, so taken/pc_next are final here
                r_pc_next  <= w_pc_nxt_calc;
                r_br_taken <= w_taken;
                if (w_md_start) begin
                    r_cnt    <= c_cnt_load;
                    r_hi     <= '0;
                    r_lo     <= w_md_div ? w_a_mag : w_b_mag;
                    r_b      <= w_md_div ? w_b_mag : w_a_mag;
                    r_neg    <= w_neg_start;
                    r_is_div <= w_md_div;
                    r_sel_hi <= w_sel_hi;
                end else begin
                    r_alu_result <= w_alu_res;
                end
            end else if (r_state == c_st_busy) begin
                r_hi  <= w_step_hi;
                r_lo  <= w_step_lo;
                r_cnt <= r_cnt - c_cnt_one;
                if (r_cnt == c_cnt_one) begin
                    r_alu_result <= w_md_result;
                end
            end
        end
    end

    assign out_valid  = (r_state == c_st_done);
    assign busy       = (r_state == c_st_busy);
    assign alu_result = r_alu_result;
    assign pc_next    = r_pc_next;
    assign br_taken   = r_br_taken;

endmodule
`default_nettype wire

// File: tb/tb_execute_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_execute_muldiv
// Description : Self-checking bench for execute_muldiv (XLEN=32). Directed
//               corner cases plus randomized ops compared against an
//               arithmetic reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_execute_muldiv;

    localparam logic [1:0] c_reg = 2'd1;
    localparam logic [1:0] c_imm = 2'd2;
    localparam logic [1:0] c_pcs = 2'd3;

    localparam logic [5:0] c_jal  = 6'd1,  c_jalr = 6'd2,  c_beq  = 6'd3;
    localparam logic [5:0] c_add  = 6'd17, c_sub  = 6'd18;
    localparam logic [5:0] c_mul  = 6'd27, c_mulh = 6'd28, c_div  = 6'd31;
    localparam logic [5:0] c_divu = 6'd32, c_remu = 6'd34;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc;
    logic [5:0]  alucode;
    logic [1:0]  aluop1_type;
    logic [1:0]  aluop2_type;
    logic [31:0] rs1, rs2, imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_result;
    logic [31:0] pc_next;
    logic        br_taken;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    execute_muldiv #(.XLEN(32), .MULDIV_EN(1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .pc(pc), .alucode(alucode),
        .aluop1_type(aluop1_type), .aluop2_type(aluop2_type),
        .rs1(rs1), .rs2(rs2), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_result(alu_result), .pc_next(pc_next),
        .br_taken(br_taken), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sel_op(input logic [1:0] t, input logic [31:0] r,
                                           input logic [31:0] i, input logic [31:0] p);
        case (t)
            2'd1:    return r;
            2'd2:    return i;
            2'd3:    return p;
            default: return 32'd0;
        endcase
    endfunction

    // Reference model: architectural result of one op
    task automatic model(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pcv, input logic [31:0] r1, input logic [31:0] iv,
                         output logic [31:0] res, output logic [31:0] pcn,
                         output logic tk, output int lat);
        longint sa, sb, sp;
        longint unsigned ua, ub, up;
        int ia, ib;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = a;
        ib = b;
        res = 32'd0;
        tk  = 1'b0;
        lat = (code >= 6'd27 && code <= 6'd34) ? 33 : 1;
        case (code)
            6'd0:  res = b;
            6'd1, 6'd2: begin res = pcv + 32'd4; tk = 1'b1; end
            6'd3:  tk = (a == b);
            6'd4:  tk = (a != b);
            6'd5:  tk = (ia < ib);
            6'd6:  tk = (ia >= ib);
            6'd7:  tk = (a < b);
            6'd8:  tk = (a >= b);
            6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15, 6'd16, 6'd17: res = a + b;
            6'd18: res = a - b;
            6'd19: res = (ia < ib) ? 32'd1 : 32'd0;
            6'd20: res = (a < b) ? 32'd1 : 32'd0;
            6'd21: res = a ^ b;
            6'd22: res = a | b;
            6'd23: res = a & b;
            6'd24: res = a << b[4:0];
            6'd25: res = a >> b[4:0];
            6'd26: res = ia >>> b[4:0];
            6'd27: begin sp = sa * sb; res = sp[31:0]; end
            6'd28: begin sp = sa * sb; res = sp[63:32]; end
            6'd29: begin sp = sa * longint'(ub); res = sp[63:32]; end
            6'd30: begin up = ua * ub; res = up[63:32]; end
            6'd31: begin
                if (b == 0) res = 32'hffff_ffff;
                else if (a == 32'h8000_0000 && b == 32'hffff_ffff) res = a;
                else res = ia / ib;
            end
            6'd32: res = (b == 0) ? 32'hffff_ffff : a / b;
            6'd33: begin
                if (b == 0) res = a;
                else if (a == 32'h8000_0000 && b == 32'hffff_ffff) res = 32'd0;
                else res = ia % ib;
            end
            6'd34: res = (b == 0) ? a : a % b;
            default: ;
        endcase
        if (tk && code == 6'd2) pcn = (r1 + iv) & 32'hffff_fffe;
        else if (tk)            pcn = pcv + iv;
        else                    pcn = pcv + 32'd4;
    endtask

    task automatic drive(input logic [5:0] code, input logic [1:0] t1, input logic [1:0] t2,
                         input logic [31:0] pcv, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] iv);
        alucode = code; aluop1_type = t1; aluop2_type = t2;
        pc = pcv; rs1 = r1; rs2 = r2; imm = iv;
        in_valid = 1'b1;
    endtask

    task automatic scramble();
        pc = $urandom; rs1 = $urandom; rs2 = $urandom; imm = $urandom;
        alucode = 6'($urandom_range(0, 63));
    endtask

    // Issue one op from IDLE, wait for completion, check it and consume it
    task automatic apply_op(input string tag, input logic [5:0] code, input logic [1:0] t1,
                            input logic [1:0] t2, input logic [31:0] pcv, input logic [31:0] r1,
                            input logic [31:0] r2, input logic [31:0] iv);
        logic [31:0] e_res, e_pcn;
        logic        e_tk;
        int          e_lat, lat;
        bit          stall_ok;
        model(code, sel_op(t1, r1, iv, pcv), sel_op(t2, r2, iv, pcv), pcv, r1, iv,
              e_res, e_pcn, e_tk, e_lat);
        drive(code, t1, t2, pcv, r1, r2, iv);
        out_ready = 1'b1;
        check({tag, "_rdy"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble();
        lat = 1;
        stall_ok = 1'b1;
        while (!out_valid && lat < 200) begin
            if (in_ready || !busy) stall_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, e_lat);
        check({tag, "_res"}, alu_result, e_res);
        check({tag, "_pcn"}, pc_next, e_pcn);
        check({tag, "_tk"}, br_taken, e_tk);
        if (e_lat > 1) check({tag, "_stall"}, stall_ok, 1);
        @(posedge clk); #1;
        check({tag, "_idle"}, out_valid, 0);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hffff_ffff;
            3:       return 32'h8000_0000;
            4:       return 32'h7fff_ffff;
            5:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] e_res_a, e_pcn_a, e_res_b, e_pcn_b;
        logic        e_tk;
        int          e_lat;
        bit          ok;

        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        pc = 0; alucode = 0; aluop1_type = 0; aluop2_type = 0;
        rs1 = 0; rs2 = 0; imm = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ov", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_res", alu_result, 0);
        check("rst_pcn", pc_next, 0);
        check("rst_tk", br_taken, 0);
        check("rst_rdy", in_ready, 1);
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed ops
        apply_op("add",   c_add,  c_reg, c_imm, 32'h0000_1000, 32'd5, 32'd0, 32'hffff_fffd);
        apply_op("beq",   c_beq,  c_reg, c_reg, 32'h0000_0100, 32'd7, 32'd7, 32'h20);
        apply_op("jalr",  c_jalr, c_reg, c_imm, 32'h0000_0300, 32'h203, 32'd0, 32'd4);
        apply_op("jal",   c_jal,  c_pcs, c_imm, 32'h0000_0400, 32'd0, 32'd0, 32'hffff_fff0);
        apply_op("mulh",  c_mulh, c_reg, c_reg, 32'h0000_0500, 32'h8000_0000, 32'h8000_0000, 0);
        apply_op("divov", c_div,  c_reg, c_reg, 32'h0000_0504, 32'h8000_0000, 32'hffff_ffff, 0);
        apply_op("remu0", c_remu, c_reg, c_reg, 32'h0000_0508, 32'h1234_5678, 32'd0, 0);
        apply_op("divu0", c_divu, c_reg, c_reg, 32'h0000_050c, 32'd7, 32'd0, 0);
        apply_op("div0",  c_div,  c_reg, c_reg, 32'h0000_0510, 32'hffff_fff9, 32'd0, 0);

        // Hold in DONE with out_ready low, then back-to-back accept
        model(c_add, 32'd100, 32'd23, 32'h600, 32'd100, 32'd0, e_res_a, e_pcn_a, e_tk, e_lat);
        model(c_sub, 32'd50, 32'd8, 32'h604, 32'd50, 32'd0, e_res_b, e_pcn_b, e_tk, e_lat);
        out_ready = 1'b0;
        drive(c_add, c_reg, c_reg, 32'h600, 32'd100, 32'd23, 32'd0);
        @(posedge clk); #1;
        drive(c_sub, c_reg, c_reg, 32'h604, 32'd50, 32'd8, 32'd0);
        for (int i = 0; i < 5; i++) begin
            check("hold_ov", out_valid, 1);
            check("hold_rdy", in_ready, 0);
            check("hold_res", alu_result, e_res_a);
            check("hold_pcn", pc_next, e_pcn_a);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        check("b2b_rdy", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b_ov", out_valid, 1);
        check("b2b_res", alu_result, e_res_b);
        check("b2b_pcn", pc_next, e_pcn_b);
        @(posedge clk); #1;
        check("b2b_idle", out_valid, 0);

        // Flush during DIV at BUSY cycle 10
        drive(c_div, c_reg, c_reg, 32'h700, 32'd1000, 32'd7, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("fl_busy", busy, 1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("fl_busy0", busy, 0);
        check("fl_ov", out_valid, 0);
        check("fl_rdy", in_ready, 1);
        ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) ok = 1'b0;
            @(posedge clk); #1;
        end
        check("fl_never_ov", ok, 1);

        // Flush with same-cycle in_valid in IDLE: op ignored
        drive(c_add, c_reg, c_reg, 32'h800, 32'd1, 32'd2, 32'd0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_ign_ov", out_valid, 0);
        check("fl_ign_busy", busy, 0);

        // Flush in DONE while result unconsumed
        out_ready = 1'b0;
        drive(c_add, c_reg, c_reg, 32'h900, 32'd3, 32'd4, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("fl_done_ov1", out_valid, 1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("fl_done_ov0", out_valid, 0);

        // Reset in the middle of a MUL
        out_ready = 1'b1;
        drive(c_mul, c_reg, c_reg, 32'ha00, 32'd12345, 32'd678, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("mrst_ov", out_valid, 0);
        check("mrst_busy", busy, 0);
        check("mrst_res", alu_result, 0);
        check("mrst_pcn", pc_next, 0);
        check("mrst_tk", br_taken, 0);
        check("mrst_rdy", in_ready, 1);
        @(posedge clk); #1;

        // Randomized ops
        for (int k = 0; k < 300; k++) begin
            logic [5:0] c;
            logic [1:0] t1, t2;
            c  = 6'($urandom_range(0, 36));
            t1 = 2'($urandom_range(0, 3));
            t2 = 2'($urandom_range(0, 3));
            if (c >= 6'd27 && c <= 6'd34 && $urandom_range(0, 3) != 0) begin
                t1 = c_reg;
                t2 = c_reg;
            end
            apply_op("rnd", c, t1, t2, $urandom & 32'hffff_fffc, rnd_val(), rnd_val(), rnd_val());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
